// File: rtl/data_memory_arbiter.sv
// Shares one data memory between the CPU MEM stage and a debug dump engine.
// The CPU always wins the read port; the dump waits and counts the cycles it lost.
module data_memory_arbiter #(
  parameter int NB_ADDR  = 10,
  parameter int NB_DATA  = 32,
  parameter int NB_COUNT = 11,
  parameter int NB_STALL = 16
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cpu_read_enable,
  input  logic                i_cpu_write_enable,
  input  logic [NB_ADDR-1:0]  i_cpu_address,
  input  logic [NB_DATA-1:0]  i_cpu_data,
  output logic [NB_DATA-1:0]  o_cpu_data,
  output logic                o_mem_read_enable,
  output logic                o_mem_write_enable,
  output logic [NB_ADDR-1:0]  o_mem_read_address,
  output logic [NB_ADDR-1:0]  o_mem_write_address,
  output logic [NB_DATA-1:0]  o_mem_data,
  input  logic [NB_DATA-1:0]  i_mem_data,
  input  logic                i_dump_start,
  input  logic [NB_ADDR-1:0]  i_dump_base,
  input  logic [NB_COUNT-1:0] i_dump_count,
  output logic [NB_DATA-1:0]  o_dump_data,
  output logic                o_dump_valid,
  input  logic                i_dump_ready,
  output logic                o_dump_busy,
  output logic                o_dump_done,
  output logic [NB_STALL-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t              state, state_next;
  logic [NB_ADDR-1:0]  addr;
  logic [NB_COUNT-1:0] remain;
  logic                grant;

  function automatic logic [NB_STALL-1:0] sat_inc(input logic [NB_STALL-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign o_mem_write_enable  = i_cpu_write_enable;
  assign o_mem_write_address = i_cpu_address;
  assign o_mem_data          = i_cpu_data;

  // The dump only sees the read port on cycles the CPU leaves the memory untouched.
  assign grant              = (state == READ) && !i_cpu_read_enable && !i_cpu_write_enable;
  assign o_mem_read_enable  = grant | i_cpu_read_enable;
  assign o_mem_read_address = grant ? addr : i_cpu_address;
  assign o_cpu_data         = i_cpu_read_enable ? i_mem_data : '0;

  assign o_dump_busy = (state != IDLE);
  assign o_dump_done = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_dump_start) state_next = (i_dump_count == '0) ? DONE : READ;
      READ: if (grant) state_next = HOLD;
      HOLD: if (i_dump_ready) state_next = (remain == NB_COUNT'(1)) ? DONE : READ;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      addr           <= '0;
      remain         <= '0;
      o_dump_data    <= '0;
      o_dump_valid   <= 1'b0;
      o_stall_cycles <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (i_dump_start) begin
            addr           <= i_dump_base;
            remain         <= i_dump_count;
            o_stall_cycles <= '0;
          end
        end
        READ: begin
          if (grant) begin
            o_dump_data  <= i_mem_data;
            o_dump_valid <= 1'b1;
          end else begin
            o_stall_cycles <= sat_inc(o_stall_cycles);
          end
        end
        HOLD: begin
          if (i_dump_ready) begin
            o_dump_valid <= 1'b0;
            addr         <= addr + 1'b1;
            remain       <= remain - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: dump words are queued at start and
// checked by a monitor whenever the debug side accepts a word.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        mem_re, mem_we;
  logic [9:0]  mem_raddr, mem_waddr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        dump_start;
  logic [9:0]  dump_base;
  logic [10:0] dump_count;
  logic [31:0] dump_data;
  logic        dump_valid, dump_ready, dump_busy, dump_done;
  logic [15:0] stall;

  logic [31:0] mem [0:1023];
  logic [31:0] sb [$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_cpu_read_enable(cpu_rd), .i_cpu_write_enable(cpu_wr),
    .i_cpu_address(cpu_addr), .i_cpu_data(cpu_wdata), .o_cpu_data(cpu_rdata),
    .o_mem_read_enable(mem_re), .o_mem_write_enable(mem_we),
    .o_mem_read_address(mem_raddr), .o_mem_write_address(mem_waddr),
    .o_mem_data(mem_wdata), .i_mem_data(mem_rdata),
    .i_dump_start(dump_start), .i_dump_base(dump_base), .i_dump_count(dump_count),
    .o_dump_data(dump_data), .o_dump_valid(dump_valid), .i_dump_ready(dump_ready),
    .o_dump_busy(dump_busy), .o_dump_done(dump_done), .o_stall_cycles(stall)
  );

  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && dump_valid && dump_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected dump word: got %0h, expected none", dump_data);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("dump word", dump_data, e);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_dump(input logic [9:0] base, input logic [10:0] cnt);
    step();
    dump_start = 1'b1; dump_base = base; dump_count = cnt;
    step();
    dump_start = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    logic found = 1'b0;
    for (int k = 0; k < max && !found; k++) begin
      @(negedge clk);
      if (dump_valid) found = 1'b1;
    end
    check("wait for valid", found, 1);
  endtask

  task automatic wait_done(input int max);
    logic found = 1'b0;
    for (int k = 0; k < max && !found; k++) begin
      @(negedge clk);
      if (dump_done) found = 1'b1;
    end
    check("wait for done", found, 1);
    @(negedge clk);
    check("done one cycle", dump_done, 0);
    check("busy after done", dump_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[4] = 32'hAAAA_0004; mem[5] = 32'hBBBB_0005; mem[6] = 32'hCCCC_0006;
    mem[8] = 32'h8888_0008; mem[12] = 32'h1212_1212; mem[13] = 32'h1313_1313;
    mem[20] = 32'h2020_2020; mem[30] = 32'h3030_3030; mem[40] = 32'h4040_4040;
    mem[50] = 32'h5050_5050; mem[1023] = 32'hFFFF_03FF; mem[0] = 32'h0000_0B0B;

    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dump_start = 1'b0; dump_base = '0; dump_count = '0; dump_ready = 1'b1;
    repeat (3) step();
    cpu_rd = 1'b1; cpu_addr = 10'd6;
    cpu_wr = 1'b1; cpu_wdata = 32'h0; cpu_addr = 10'd6;
    @(negedge clk);
    check("reset busy", dump_busy, 0);
    check("reset valid", dump_valid, 0);
    check("reset done", dump_done, 0);
    check("reset stall", stall, 0);
    check("reset dump data", dump_data, 0);
    check("reset cpu read path", cpu_rdata, 32'hCCCC_0006);
    check("reset write enable", mem_we, 1);
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    mem[6] = 32'hCCCC_0006;
    rst_n = 1'b1;

    // basic dump of three words
    sb.push_back(32'hAAAA_0004); sb.push_back(32'hBBBB_0005); sb.push_back(32'hCCCC_0006);
    start_dump(10'd4, 11'd3);
    @(negedge clk);
    check("busy during dump", dump_busy, 1);
    wait_done(20);
    check("basic stall", stall, 0);
    check("basic queue drained", sb.size(), 0);

    // CPU holds the read port for 5 cycles
    sb.push_back(32'h8888_0008);
    start_dump(10'd8, 11'd1);
    cpu_rd = 1'b1; cpu_addr = 10'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("contention cpu data", cpu_rdata, 32'h2020_2020);
      check("contention read addr", mem_raddr, 10'd20);
      check("contention no valid", dump_valid, 0);
      step();
    end
    cpu_rd = 1'b0;
    wait_done(10);
    check("contention stall", stall, 5);

    // backpressure in HOLD, with a CPU store going through
    dump_ready = 1'b0;
    sb.push_back(32'h1212_1212); sb.push_back(32'h1313_1313);
    start_dump(10'd12, 11'd2);
    wait_valid(10);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin cpu_wr = 1'b1; cpu_addr = 10'd100; cpu_wdata = 32'hCAFE_F00D; end
      else cpu_wr = 1'b0;
      @(negedge clk);
      check("hold data stable", dump_data, 32'h1212_1212);
      check("hold valid stable", dump_valid, 1);
      check("hold no mem read", mem_re, 0);
      if (i == 0) begin
        check("store write enable", mem_we, 1);
        check("store write addr", mem_waddr, 10'd100);
        check("store write data", mem_wdata, 32'hCAFE_F00D);
      end
    end
    step();
    dump_ready = 1'b1;
    wait_done(20);
    step();
    cpu_rd = 1'b1; cpu_addr = 10'd100;
    @(negedge clk);
    check("stored word readback", cpu_rdata, 32'hCAFE_F00D);
    step();
    cpu_rd = 1'b0;
    @(negedge clk);
    check("cpu data zero when idle", cpu_rdata, 0);

    // address wrap
    sb.push_back(32'hFFFF_03FF); sb.push_back(32'h0000_0B0B);
    start_dump(10'd1023, 11'd2);
    wait_done(20);

    // zero count
    start_dump(10'd4, 11'd0);
    @(negedge clk);
    check("zero count done", dump_done, 1);
    check("zero count valid", dump_valid, 0);
    @(negedge clk);
    check("zero count done width", dump_done, 0);
    check("zero count idle", dump_busy, 0);

    // second start during READ is ignored
    sb.push_back(32'h4040_4040);
    start_dump(10'd40, 11'd1);
    dump_start = 1'b1; dump_base = 10'd50; dump_count = 11'd5;
    cpu_rd = 1'b1; cpu_addr = 10'd20;
    step();
    step();
    dump_start = 1'b0; cpu_rd = 1'b0;
    wait_done(10);
    check("restart ignored stall", stall, 2);

    // reset while in HOLD
    dump_ready = 1'b0;
    start_dump(10'd30, 11'd2);
    wait_valid(10);
    check("hold before reset", dump_data, 32'h3030_3030);
    step();
    rst_n = 1'b0; cpu_rd = 1'b1; cpu_addr = 10'd5;
    step();
    @(negedge clk);
    check("reset abort valid", dump_valid, 0);
    check("reset abort busy", dump_busy, 0);
    check("reset abort data", dump_data, 0);
    check("reset cpu data", cpu_rdata, 32'hBBBB_0005);
    step();
    rst_n = 1'b1; cpu_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no done after reset", dump_done, 0);
    end
    check("final queue empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameters SHALL be:
- NB_ADDR, default 10, memory address width.
- NB_DATA, default 32, data width.
- NB_COUNT, default 11, dump word-count width.
- NB_STALL, default 16, stall counter width.

REQ-002 Ports SHALL be, in this order (name, direction, width, meaning):
- i_clock  in  1  single clock, all state on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_cpu_read_enable  in  1  MEM-stage load.
- i_cpu_write_enable  in  1  MEM-stage store.
- i_cpu_address  in  NB_ADDR  MEM-stage address.
- i_cpu_data  in  NB_DATA  store data.
- o_cpu_data  out  NB_DATA  load data.
- o_mem_read_enable  out  1  to data memory.
- o_mem_write_enable  out  1  to data memory.
- o_mem_read_address  out  NB_ADDR  to data memory.
- o_mem_write_address  out  NB_ADDR  to data memory.
- o_mem_data  out  NB_DATA  write data to memory.
- i_mem_data  in  NB_DATA  combinational read data from memory.
- i_dump_start  in  1  debug-unit dump request pulse.
- i_dump_base  in  NB_ADDR  first dump address.
- i_dump_count  in  NB_COUNT  number of words to dump.
- o_dump_data  out  NB_DATA  dumped word, registered.
- o_dump_valid  out  1  o_dump_data valid.
- i_dump_ready  in  1  debug unit accepts word.
- o_dump_busy  out  1  dump in progress.
- o_dump_done  out  1  one-cycle completion pulse.
- o_stall_cycles  out  NB_STALL  cycles the dump waited on the CPU.

Function
REQ-003 The block SHALL share the single data memory between the CPU MEM stage and the debug dump engine, with the CPU having absolute priority; the CPU is never stalled.

REQ-004 Write port: o_mem_write_enable, o_mem_write_address and o_mem_data SHALL equal i_cpu_write_enable, i_cpu_address and i_cpu_data combinationally at all times.

REQ-005 Read-port grant: the dump SHALL drive the read port only in state READ while i_cpu_read_enable=0 and i_cpu_write_enable=0. In all other cycles the read port SHALL carry i_cpu_read_enable and i_cpu_address.

REQ-006 o_cpu_data SHALL equal i_mem_data when i_cpu_read_enable=1, and 0 otherwise.

REQ-007 FSM states SHALL be IDLE, READ, HOLD and DONE.

REQ-008 IDLE: on i_dump_start=1, latch addr=i_dump_base and remain=i_dump_count, and clear o_stall_cycles.
- If i_dump_count=0, go to DONE.
- Otherwise, go to READ.

REQ-009 READ:
- If granted: capture i_mem_data into o_dump_data, set o_dump_valid=1 on the next edge, and go to HOLD.
- If not granted: stay in READ and increment o_stall_cycles, saturating at all-ones.

REQ-010 HOLD: o_dump_valid and o_dump_data SHALL stay stable until i_dump_ready=1. On the accepting edge:
- clear o_dump_valid;
- set addr=addr+1, wrapping modulo 2^NB_ADDR;
- set remain=remain-1;
- go to DONE if remain was 1, else go to READ.

REQ-011 DONE: o_dump_done=1 for exactly one cycle, then go to IDLE.

REQ-012 o_dump_busy SHALL be 1 in READ, HOLD and DONE, and 0 in IDLE.

REQ-013 i_dump_start SHALL be ignored outside IDLE. i_dump_ready SHALL be ignored outside HOLD.

REQ-014 Minimum per-word latency SHALL be 2 cycles: READ→HOLD, then accept with ready=1.

REQ-015 The dump SHALL never assert a memory write.

Reset
REQ-016 While i_reset_n=0 at a rising edge, the block SHALL:
- enter IDLE;
- clear o_dump_data, o_dump_valid, o_dump_done, o_stall_cycles, addr and remain.

REQ-017 Reset mid-dump SHALL abort immediately with no o_dump_done pulse. The combinational CPU paths (REQ-004, REQ-006) SHALL remain functional during reset.

Verification
REQ-018 Basic dump: mem[4..6]=A,B,C; start base=4, count=3; ready held 1; CPU idle → valid words A,B,C on 3 accepts, busy high, done pulse 1 cycle after third accept, stall=0.

REQ-019 CPU contention: count=1, base=8; CPU read held for 5 cycles from start → dump read waits, stall=5, o_cpu_data correct throughout, then word mem[8] delivered.

REQ-020 Backpressure: ready=0 for 4 cycles in HOLD → o_dump_data and valid stable, addr unchanged, no memory read issued.

REQ-021 Wrap and zero count:
- base=1023, count=2 → words mem[1023], mem[0].
- count=0 → done pulse 1 cycle after start, valid never asserted.

REQ-022 Reset and restart:
- i_reset_n=0 during HOLD → next cycle IDLE, valid=0, no done pulse.
- A second start during READ is ignored.
- CPU store during a dump writes through unchanged (REQ-004).
